// File: rtl/lcd1602_pkg.sv
// lcd1602_pkg: shared definitions for the LCD1602 write path and the init sequencer.
//   - one-hot FSM state encoding for the bus writer
//   - default HD44780 timing constants at a 50 MHz clock
//   - common instruction bytes
//   - helper that recognises the slow clear/home instructions
package lcd1602_pkg;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_SETUP = 5'b00010,
    ST_PULSE = 5'b00100,
    ST_HOLD  = 5'b01000,
    ST_EXEC  = 5'b10000
  } lcd_state_t;

  localparam int T_AS_DEF   = 3;
  localparam int T_PW_DEF   = 25;
  localparam int T_H_DEF    = 3;
  localparam int T_EXEC_DEF = 2_500;
  localparam int T_CLR_DEF  = 100_000;
  localparam int CNT_W_DEF  = 17;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_FUNC  = 8'h38;
  localparam logic [7:0] CMD_DOFF  = 8'h08;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_DON   = 8'h0C;

  // Clear (0000_000x) and home (0000_001x) need the long execution wait.
  function automatic logic is_clear_home(input logic [7:0] b);
    return (b[7:1] == 7'b0000000) || (b[7:1] == 7'b0000001);
  endfunction

endpackage

// File: rtl/lcd1602_write_if.sv
// lcd1602_write_if: request/response handshake between a requester (init
// sequencer, display-update logic) and the LCD1602 bus writer.
//   cmd_en/cmd    one-cycle instruction write request and byte
//   data_en/data  one-cycle character write request and byte
//   cmd_done      one-cycle completion pulse from the writer
//   busy          writer is not idle
interface lcd1602_write_if;
  logic       cmd_en;
  logic [7:0] cmd;
  logic       data_en;
  logic [7:0] data;
  logic       cmd_done;
  logic       busy;

  modport master (
    output cmd_en, cmd, data_en, data,
    input  cmd_done, busy
  );

  modport slave (
    input  cmd_en, cmd, data_en, data,
    output cmd_done, busy
  );
endinterface

// File: rtl/lcd1602_write.sv
// lcd1602_write: accepts one byte per request and drives the HD44780 8-bit
// parallel bus with setup, E-pulse and hold timing, then waits out the
// controller execution time before pulsing cmd_done.
// Ports:
//   clk     system clock (50 MHz nominal)
//   rst     asynchronous active-high reset
//   bus     slave side of lcd1602_write_if (cmd_en/cmd, data_en/data in;
//           cmd_done/busy out)
//   lcd_rs  register select (0 = instruction, 1 = character)
//   lcd_rw  read/write, permanently write
//   lcd_e   enable strobe
//   lcd_db  8-bit data bus
module lcd1602_write
  import lcd1602_pkg::*;
#(
  parameter int T_AS   = T_AS_DEF,
  parameter int T_PW   = T_PW_DEF,
  parameter int T_H    = T_H_DEF,
  parameter int T_EXEC = T_EXEC_DEF,
  parameter int T_CLR  = T_CLR_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd1602_write_if.slave        bus,
  output logic                  lcd_rs,
  output logic                  lcd_rw,
  output logic                  lcd_e,
  output logic [7:0]            lcd_db
);

  // Timer reload values: a phase lasting N cycles loads N-1 and exits at 0.
  localparam logic [CNT_W-1:0] LD_AS   = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] LD_PW   = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] LD_H    = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] LD_EXEC = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_CLR  = CNT_W'(T_CLR - 1);

  lcd_state_t       r_state;
  logic [CNT_W-1:0] r_timer;
  logic             w_timer_zero;
  logic             w_long_exec;

  assign lcd_rw       = 1'b0;
  assign w_timer_zero = (r_timer == '0);
  // Data writes never take the long wait, whatever the byte value.
  assign w_long_exec  = !lcd_rs && is_clear_home(lcd_db);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      bus.cmd_done <= 1'b0;
      bus.busy     <= 1'b0;
      lcd_rs       <= 1'b0;
      lcd_e        <= 1'b0;
      lcd_db       <= 8'h00;
    end else begin
      bus.cmd_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Instruction has priority when both requests coincide.
          if (bus.cmd_en || bus.data_en) begin
            lcd_db   <= bus.cmd_en ? bus.cmd : bus.data;
            lcd_rs   <= !bus.cmd_en;
            r_timer  <= LD_AS;
            r_state  <= ST_SETUP;
            bus.busy <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (w_timer_zero) begin
            r_timer <= LD_PW;
            r_state <= ST_PULSE;
            lcd_e   <= 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_PULSE: begin
          if (w_timer_zero) begin
            r_timer <= LD_H;
            r_state <= ST_HOLD;
            lcd_e   <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_timer_zero) begin
            r_timer <= w_long_exec ? LD_CLR : LD_EXEC;
            r_state <= ST_EXEC;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_EXEC: begin
          if (w_timer_zero) begin
            r_state      <= ST_IDLE;
            bus.cmd_done <= 1'b1;
            bus.busy     <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_timer  <= '0;
          bus.busy <= 1'b0;
          lcd_e    <= 1'b0;
        end
      endcase
    end
  end

endmodule
